// File: rtl/axi_debug_regs_if.sv
// rtl/axi_debug_regs_if.sv - AXI4-Lite bus bundle between the uart_debug bridge and the debug register bank
interface axi_debug_regs_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_prot;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_prot;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_debug_regs.sv
// rtl/axi_debug_regs.sv - AXI4-Lite debug register bank: ID, CTRL, STATUS, atomic cycle counter, scratch
module axi_debug_regs #(
  parameter int          ADDR_W      = 18,
  parameter int          DATA_W      = 16,
  parameter logic [15:0] ID_VALUE    = 16'hD5B9,
  parameter logic [15:0] CTRL_RESET  = 16'h0000,
  parameter int          NUM_SCRATCH = 4,
  parameter bit          USE_STRB    = 1'b0
) (
  input  logic               a_clk,
  input  logic               a_rst,
  axi_debug_regs_if.slave    bus,
  output logic [15:0]        ctrl_out,
  input  logic [15:0]        status_in
);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam int         SW     = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  typedef enum logic [2:0] {K_ID, K_CTRL, K_STATUS, K_CYC_LO, K_CYC_HI, K_CNT, K_SCR, K_NONE} kind_t;

  function automatic kind_t decode(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(16) && a < ADDR_W'(16 + NUM_SCRATCH)) return K_SCR;
    case (a)
      ADDR_W'(0): return K_ID;
      ADDR_W'(1): return K_CTRL;
      ADDR_W'(2): return K_STATUS;
      ADDR_W'(3): return K_CYC_LO;
      ADDR_W'(4): return K_CYC_HI;
      ADDR_W'(5): return K_CNT;
      default:    return K_NONE;
    endcase
  endfunction

  logic              aw_full, w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [15:0]       w_data_q;
  logic [1:0]        w_strb_q;
  logic [15:0]       ctrl_q;
  logic [15:0]       scratch [NUM_SCRATCH];
  logic [31:0]       counter;
  logic [15:0]       shadow;
  logic              cnt_en;
  logic              b_valid_q, r_valid_q;
  logic [1:0]        b_resp_q, r_resp_q;
  logic [15:0]       r_data_q;

  logic              aw_hs, w_hs, ar_hs, commit, lane0, cnt_clr;
  kind_t             wr_kind, rd_kind;
  logic [SW-1:0]     wr_idx, rd_idx;
  logic [15:0]       wr_mask, rd_data;
  logic [1:0]        wr_resp, rd_resp;

  wire unused = ^{bus.aw_prot, bus.ar_prot, w_strb_q};

  // Readies are gated by reset so nothing is accepted while the bank is held in reset.
  assign bus.aw_ready = a_rst && !aw_full;
  assign bus.w_ready  = a_rst && !w_full;
  assign bus.ar_ready = a_rst && !r_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign ctrl_out     = ctrl_q;

  assign aw_hs   = bus.aw_valid && bus.aw_ready;
  assign w_hs    = bus.w_valid && bus.w_ready;
  assign ar_hs   = bus.ar_valid && bus.ar_ready;
  assign commit  = aw_full && w_full && !b_valid_q;
  assign wr_kind = decode(aw_addr_q);
  assign rd_kind = decode(bus.ar_addr);
  assign wr_idx  = SW'(aw_addr_q - ADDR_W'(16));
  assign rd_idx  = SW'(bus.ar_addr - ADDR_W'(16));
  assign wr_mask = USE_STRB ? {{8{w_strb_q[1]}}, {8{w_strb_q[0]}}} : 16'hFFFF;
  assign lane0   = !USE_STRB || w_strb_q[0];
  assign cnt_clr = commit && (wr_kind == K_CNT) && lane0 && w_data_q[0];

  always_comb begin
    wr_resp = SLVERR;
    case (wr_kind)
      K_CTRL, K_CNT, K_SCR: wr_resp = OKAY;
      K_NONE:               wr_resp = DECERR;
      default:              wr_resp = SLVERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    case (rd_kind)
      K_ID:     rd_data = ID_VALUE;
      K_CTRL:   rd_data = ctrl_q;
      K_STATUS: rd_data = status_in;
      K_CYC_LO: rd_data = counter[15:0];
      K_CYC_HI: rd_data = shadow;
      K_CNT:    rd_data = {14'b0, cnt_en, 1'b0};
      K_SCR:    rd_data = scratch[rd_idx];
      default:  rd_resp = DECERR;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ctrl_q    <= CTRL_RESET;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      counter   <= '0;
      shadow    <= '0;
      cnt_en    <= 1'b1;
      b_valid_q <= 1'b0;
      b_resp_q  <= OKAY;
      r_valid_q <= 1'b0;
      r_resp_q  <= OKAY;
      r_data_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= bus.aw_addr;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= bus.w_data;
        w_strb_q <= bus.w_strb;
      end
      if (b_valid_q && bus.b_ready) b_valid_q <= 1'b0;
      if (commit) begin
        aw_full   <= 1'b0;
        w_full    <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp;
        case (wr_kind)
          K_CTRL:  ctrl_q <= (ctrl_q & ~wr_mask) | (w_data_q & wr_mask);
          K_CNT:   if (lane0) cnt_en <= w_data_q[1];
          K_SCR:   scratch[wr_idx] <= (scratch[wr_idx] & ~wr_mask) | (w_data_q & wr_mask);
          default: ;
        endcase
      end
      // Clear from a CNT_CTRL write wins over the free-running increment.
      if (cnt_clr)     counter <= '0;
      else if (cnt_en) counter <= counter + 32'd1;
      if (r_valid_q && bus.r_ready) r_valid_q <= 1'b0;
      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_resp;
        if (rd_kind == K_CYC_LO) shadow <= counter[31:16];
      end
    end
  end
endmodule

// File: doc/axi_debug_regs.md
Name: axi_debug_regs

Overview:
AXI4-Lite responder (subordinate) holding a small debug register bank: ID, control output, status input, 32-bit cycle counter and scratch words. It sits on the same AXI bus as bram_axi/sram_axi and answers the uart_debug bridge, which is the initiator. Addresses are 16-bit word addresses (18-bit bus), matching the bridge. Every read and write gets a response code.

Parameters:
ADDR_W, 18, AXI address width (word address)
DATA_W, 16, data width; fixed at 16 for this bank
ID_VALUE, 16'hD5B9, constant returned by the ID register
CTRL_RESET, 16'h0000, reset value of CTRL/ctrl_out
NUM_SCRATCH, 4, number of scratch words (1..16)
USE_STRB, 0, 1: honour w_strb byte lanes; 0: ignore w_strb, write the full word (uart_debug drives 2'b00)

Ports:
a_clk  in  1  clock
a_rst  in  1  asynchronous active-low reset
aw_valid/aw_ready  in/out  1  write address handshake
aw_addr  in  ADDR_W  write word address
aw_prot  in  3  ignored
w_valid/w_ready  in/out  1  write data handshake
w_data  in  DATA_W  write data
w_strb  in  DATA_W/8  byte enables (bit0 = [7:0])
b_valid/b_ready  out/in  1  write response handshake
b_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
ar_valid/ar_ready  in/out  1  read address handshake
ar_addr  in  ADDR_W  read word address
ar_prot  in  3  ignored
r_valid/r_ready  out/in  1  read data handshake
r_data  out  DATA_W  read data
r_resp  out  2  same encoding as b_resp
ctrl_out  out  16  CTRL register contents
status_in  in  16  sampled on read of STATUS

Behaviour:
- Register map (word addr): 0x00 ID RO; 0x01 CTRL RW; 0x02 STATUS RO (= status_in); 0x03 CYC_LO RO; 0x04 CYC_HI RO (shadow); 0x05 CNT_CTRL RW (bit1 = enable; bit0 = clear, write-only, reads 0; bits[15:2] read 0); 0x10..0x10+NUM_SCRATCH-1 scratch RW.
- Reset (a_rst low, async): b_valid=0, r_valid=0, b_resp=00, r_resp=00, r_data=0, ctrl_out=CTRL_RESET, scratch=0, counter=0, shadow=0, enable=1. aw/w buffers are emptied. All readies are forced 0 while a_rst is low.
- Write path: separate AW and W holding registers. aw_ready = AW buffer empty; w_ready = W buffer empty. AW and W may arrive in either order or in the same cycle.
- Commit: on the first edge where both buffers are full and b_valid=0, perform the write, set b_valid=1 with b_resp, and empty both buffers. AW+W in the same cycle gives b_valid one cycle after the handshake.
- b_valid holds until b_ready is sampled high. New AW/W may be buffered meanwhile, but the next commit waits until b_valid clears.
- Write responses: RW/scratch target gives OKAY. RO target gives SLVERR, no state change. Unmapped address gives DECERR, no state change. With USE_STRB=1 only enabled lanes update; w_strb=00 gives OKAY with no change.
- Read path: ar_ready = !r_valid (one outstanding read). On the AR handshake edge, r_data/r_resp are registered and r_valid=1. r_valid clears on r_valid&&r_ready.
- Read responses: unmapped address gives r_data=0, DECERR; all else OKAY.
- Read/write collision: a read and a write commit to the same register on the same edge return the old value.
- Counter: 32-bit; increments every cycle while enable=1 and wraps 0xFFFFFFFF to 0. A CNT_CTRL write with bit0=1 zeroes the counter on the commit edge, taking precedence over increment. Enable takes bit1 of the same write.
- Atomic counter read: reading CYC_LO returns counter[15:0] as of the AR edge and loads shadow with counter[31:16] on the same edge. CYC_HI returns the shadow, not the live value.

Test Plan:
- After reset release, read 0x00 -> r_data=16'hD5B9, r_resp=00, r_valid one cycle after AR handshake; ctrl_out=0.
- W (data 16'hAA55) 3 cycles before AW (addr 0x01), b_ready held low 4 cycles -> ctrl_out=16'hAA55 after commit; b_valid stays high until b_ready; b_resp=00; aw_ready low while AW is buffered.
- Write 0x10=16'hDEAD and 0x13=16'hBEEF, read both back -> DEAD/BEEF, OKAY. Write/read 0x14 with NUM_SCRATCH=4 -> DECERR, r_data=0. Write 0x00 -> SLVERR, ID unchanged.
- Write CNT_CTRL=16'h0003, wait 70000 cycles, read CYC_LO then CYC_HI -> {HI,LO} equals counter value at LO AR edge (past 0xFFFF carry); CNT_CTRL=0 freezes the count.
- USE_STRB=1, write CTRL=16'h1234 strb=10 over 16'h00FF -> 16'h12FF; strb=00 -> OKAY, unchanged.
- Assert a_rst while AW buffered and r_valid high -> r_valid=0, b_valid=0, buffers empty, ctrl_out=CTRL_RESET; no write commits after release.
